// File: rtl/dram_timing_ctrl.sv
// DRAM timing/refresh companion of command_FSM: per-state completion strobes,
// periodic refresh requests and refresh-overrun flag. Optional macro: REF_POSTPONE_EN.
package dram_pack;
    typedef enum logic [3:0] {
        POWER_UP, IDLE, LOAD_MODE, ACTIVATING, READING,
        WRITING, PRECHARGE, REFRESH, ZQ_CAL
    } cmd_state_t;
endpackage

module dram_timing_ctrl
    import dram_pack::*;
#(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned T_INIT = 1000,
    parameter int unsigned T_RCD  = 11,
    parameter int unsigned T_RD   = 15,
    parameter int unsigned T_WR   = 25,
    parameter int unsigned T_RP   = 11,
    parameter int unsigned T_RFC  = 208,
    parameter int unsigned T_REFI = 6240
) (
    input  logic       CLK,
    input  logic       nRST,
    input  cmd_state_t cmd_state,
    output logic       init_done,
    output logic       tACT_done,
    output logic       tRD_done,
    output logic       tWR_done,
    output logic       tPRE_done,
    output logic       tREF_done,
    output logic       rf_req,
    output logic       ref_overrun
);
`ifdef REF_POSTPONE_EN
    localparam int unsigned PEND_W = 4;
    localparam int unsigned CAP    = 8;
`else
    localparam int unsigned PEND_W = 1;
    localparam int unsigned CAP    = 1;
`endif
    localparam int unsigned TMR_W = (T_REFI > 1) ? $clog2(T_REFI) : 1;

    cmd_state_t        prev_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d, elapsed;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              arm_q, arm_d, ovr_q, ovr_d, rf_req_q, rf_req_d;
    logic              entry, tick, ack;

    // elapsed is 0 in the first cycle of any state, so cycle T sees T-1
    always_comb begin
        entry   = (cmd_state != prev_q);
        elapsed = entry ? '0 : cnt_q;
        cnt_d   = (&elapsed) ? elapsed : elapsed + CNT_W'(1);
    end

    // Strobes are combinational; gating with nRST keeps them low while in reset
    assign init_done = nRST && cmd_state == POWER_UP   && elapsed == CNT_W'(T_INIT - 1);
    assign tACT_done = nRST && cmd_state == ACTIVATING && elapsed == CNT_W'(T_RCD - 1);
    assign tRD_done  = nRST && cmd_state == READING    && elapsed == CNT_W'(T_RD - 1);
    assign tWR_done  = nRST && cmd_state == WRITING    && elapsed == CNT_W'(T_WR - 1);
    assign tPRE_done = nRST && cmd_state == PRECHARGE  && elapsed == CNT_W'(T_RP - 1);
    assign tREF_done = nRST && cmd_state == REFRESH    && elapsed == CNT_W'(T_RFC - 1);

    always_comb begin
        arm_d  = arm_q | init_done;
        tick   = arm_q && (tmr_q == TMR_W'(T_REFI - 1));
        tmr_d  = (!arm_q || tick) ? '0 : tmr_q + TMR_W'(1);
        ack    = entry && (cmd_state == REFRESH);
        pend_d = pend_q;
        ovr_d  = ovr_q;
        if (tick && !ack) begin
            if (pend_q == PEND_W'(CAP)) ovr_d = 1'b1;
            else                        pend_d = pend_q + PEND_W'(1);
        end else if (ack && !tick && pend_q != '0) begin
            pend_d = pend_q - PEND_W'(1);
        end
        rf_req_d = (pend_d != '0);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            prev_q   <= POWER_UP;
            cnt_q    <= '0;
            tmr_q    <= '0;
            arm_q    <= 1'b0;
            pend_q   <= '0;
            ovr_q    <= 1'b0;
            rf_req_q <= 1'b0;
        end else begin
            prev_q   <= cmd_state;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            arm_q    <= arm_d;
            pend_q   <= pend_d;
            ovr_q    <= ovr_d;
            rf_req_q <= rf_req_d;
        end
    end

    assign rf_req      = rf_req_q;
    assign ref_overrun = ovr_q;
endmodule
